// File: rtl/dm_load_unit.sv
// Load-side data-memory port: alignment/range check, single word read, lane select
// and sign/zero extension, returned to WB over a valid/ready handshake.
module dm_load_unit #(
  parameter logic [31:0] ADDR_LO = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI = 32'h0000_3FFF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_pc,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] rsp_pc,
  output logic        adel,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef enum logic [2:0] {
    LD_LW  = 3'b000,
    LD_LH  = 3'b001,
    LD_LHU = 3'b010,
    LD_LB  = 3'b011,
    LD_LBU = 3'b100
  } ld_type_t;

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [1:0]       addr_lo_q;
  logic [2:0]       type_q;
  logic [31:0]      pc_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      rsp_data_q;
  logic             adel_q, bus_err_q;
  logic [CNT_W-1:0] wait_cnt;

  logic             misaligned, out_of_range, req_bad;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;
  logic [31:0]      load_val;

  // Offset compare keeps the range check correct for any ADDR_LO, including 0.
  always_comb begin
    misaligned = 1'b0;
    case (req_type)
      LD_LH, LD_LHU: misaligned = req_addr[0];
      LD_LB, LD_LBU: misaligned = 1'b0;
      default:       misaligned = |req_addr[1:0];
    endcase
    out_of_range = (req_addr - ADDR_LO) > (ADDR_HI - ADDR_LO);
    req_bad      = misaligned | out_of_range;
  end

  always_comb begin
    lane_b   = mem_rdata[{addr_lo_q, 3'b000} +: 8];
    lane_h   = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_val = mem_rdata;
    case (type_q)
      LD_LH:   load_val = {{16{lane_h[15]}}, lane_h};
      LD_LHU:  load_val = {16'h0000, lane_h};
      LD_LB:   load_val = {{24{lane_b[7]}}, lane_b};
      LD_LBU:  load_val = {24'h00_0000, lane_b};
      default: load_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = req_bad ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        mem_rd_en = 1'b1;
        state_nx  = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid || (wait_cnt == CNT_LAST)) state_nx = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // mem_addr is only reloaded on the way into ISSUE, so rejected requests leave it intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_lo_q  <= '0;
      type_q     <= '0;
      pc_q       <= '0;
      mem_addr_q <= '0;
      rsp_data_q <= '0;
      adel_q     <= 1'b0;
      bus_err_q  <= 1'b0;
      wait_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            addr_lo_q <= req_addr[1:0];
            type_q    <= req_type;
            pc_q      <= req_pc;
            if (req_bad) begin
              rsp_data_q <= '0;
              adel_q     <= 1'b1;
              bus_err_q  <= 1'b0;
            end else begin
              mem_addr_q <= {req_addr[31:2], 2'b00};
            end
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          if (mem_rvalid) begin
            rsp_data_q <= load_val;
            adel_q     <= 1'b0;
            bus_err_q  <= 1'b0;
          end else if (wait_cnt == CNT_LAST) begin
            rsp_data_q <= '0;
            adel_q     <= 1'b0;
            bus_err_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            adel_q    <= 1'b0;
            bus_err_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = mem_addr_q;
  assign rsp_data = rsp_data_q;
  assign rsp_pc   = pc_q;
  assign adel     = adel_q;
  assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_dm_load_unit.sv
// Scoreboard bench for dm_load_unit: a small DM model answers read strobes, expected
// responses are queued at request time and popped when the unit responds.
module tb_dm_load_unit;

  localparam int unsigned TIMEOUT = 16;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        adel;
    logic        bus_err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [2:0]  req_type;
  logic [31:0] req_pc;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [31:0] rsp_pc;
  logic        adel;
  logic        bus_err;

  always #5 clk = ~clk;

  dm_load_unit #(
    .ADDR_LO(32'h0000_0000),
    .ADDR_HI(32'h0000_3FFF),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_type(req_type), .req_pc(req_pc),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_pc(rsp_pc),
    .adel(adel), .bus_err(bus_err)
  );

  int   vectors = 0;
  int   miscompares = 0;
  rsp_t exp_q[$];

  logic [31:0] dm [16];
  logic        dm_enable = 1'b1;
  logic        rd_seen = 1'b0;
  logic [3:0]  rd_idx = '0;
  int          cyc = 0;
  int          stray_at = -1;

  // 1-cycle DM: a strobe seen in cycle N is answered in cycle N+1; stray pulses carry junk data.
  always @(negedge clk) begin
    rd_seen = mem_rd_en && dm_enable;
    if (mem_rd_en) rd_idx = mem_addr[5:2];
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    mem_rvalid = rd_seen || (cyc == stray_at);
    mem_rdata  = rd_seen ? dm[rd_idx] : 32'h5A5A_A5A5;
  end

  function automatic rsp_t model(input logic [31:0] a, input logic [2:0] t,
                                 input logic [31:0] pc, input logic mem_on);
    rsp_t r;
    logic [31:0] w, sh;
    logic bad;
    r = '0;
    r.pc = pc;
    case (t)
      3'd1, 3'd2: bad = a[0];
      3'd3, 3'd4: bad = 1'b0;
      default:    bad = (a[1:0] != 2'b00);
    endcase
    if (a > 32'h0000_3FFF) bad = 1'b1;
    if (bad) r.adel = 1'b1;
    else if (!mem_on) r.bus_err = 1'b1;
    else begin
      w = dm[a[5:2]];
      case (t)
        3'd1: begin sh = w >> (a[1] ? 16 : 0); r.data = {{16{sh[15]}}, sh[15:0]}; end
        3'd2: begin sh = w >> (a[1] ? 16 : 0); r.data = {16'h0, sh[15:0]}; end
        3'd3: begin sh = w >> (8 * a[1:0]);    r.data = {{24{sh[7]}}, sh[7:0]}; end
        3'd4: begin sh = w >> (8 * a[1:0]);    r.data = {24'h0, sh[7:0]}; end
        default: r.data = w;
      endcase
    end
    return r;
  endfunction

  task automatic send(input logic [31:0] a, input logic [2:0] t, input logic [31:0] pc);
    req_valid = 1'b1;
    req_addr  = a;
    req_type  = t;
    req_pc    = pc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Returns at the negedge of the first rsp_valid cycle; lat counts cycles after acceptance, 0 = none.
  task automatic collect(output int lat, output rsp_t got, output logic rd_s, output logic [31:0] rd_a);
    lat = 0; got = '0; rd_s = 1'b0; rd_a = '0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (mem_rd_en) begin rd_s = 1'b1; rd_a = mem_addr; end
      if (rsp_valid) begin
        lat = i;
        got = {rsp_data, rsp_pc, adel, bus_err};
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h10; req_type = 3'd0; req_pc = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if ({mem_rd_en, rsp_valid, adel, bus_err, req_ready} !== 5'b00001) begin
      miscompares++;
      $display("FAIL reset_ctrl: got rd_en/rsp_valid/adel/bus_err/req_ready=%b expected 00001",
               {mem_rd_en, rsp_valid, adel, bus_err, req_ready});
    end
    vectors++;
    if ({mem_addr, rsp_data, rsp_pc} !== 96'h0) begin
      miscompares++;
      $display("FAIL reset_data: got mem_addr=%h rsp_data=%h rsp_pc=%h expected all 0",
               mem_addr, rsp_data, rsp_pc);
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] la [7] = '{32'h13, 32'h12, 32'h10, 32'h11, 32'h12, 32'h10, 32'h10};
  logic [2:0]  lt [7] = '{3'd3, 3'd4, 3'd3, 3'd4, 3'd1, 3'd2, 3'd0};
  logic [31:0] le [7] = '{32'hFFFF_FF88, 32'h0000_0099, 32'hFFFF_FFBB, 32'h0000_00AA,
                          32'hFFFF_8899, 32'h0000_AABB, 32'h8899_AABB};

  task automatic test_lanes();
    int lat; rsp_t got, e; logic rd_s; logic [31:0] rd_a, wa, pc;
    for (int i = 0; i < 7; i++) begin
      pc = 32'h400 + 32'(i * 4);
      wa = la[i];
      exp_q.push_back({le[i], pc, 1'b0, 1'b0});
      send(la[i], lt[i], pc);
      collect(lat, got, rd_s, rd_a);
      e = exp_q.pop_front();
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL lanes[%0d] rsp: got %h expected %h", i, got, e);
      end
      vectors++;
      if (lat !== 3) begin
        miscompares++;
        $display("FAIL lanes[%0d] latency: got %0d expected 3", i, lat);
      end
      vectors++;
      if ({rd_s, rd_a} !== {1'b1, wa[31:2], 2'b00}) begin
        miscompares++;
        $display("FAIL lanes[%0d] mem_addr: got rd=%b addr=%h expected rd=1 addr=%h",
                 i, rd_s, rd_a, {wa[31:2], 2'b00});
      end
      @(posedge clk); #1;
    end
  endtask

  logic [31:0] aa [6] = '{32'h11, 32'h4000, 32'h13, 32'h3FFF, 32'h3FFC, 32'h4000};
  logic [2:0]  at [6] = '{3'd0, 3'd1, 3'd1, 3'd4, 3'd0, 3'd3};
  logic        ab [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  task automatic test_adel();
    int lat; rsp_t got, e; logic rd_s; logic [31:0] rd_a;
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(model(aa[i], at[i], 32'h800 + 32'(i), 1'b1));
      send(aa[i], at[i], 32'h800 + 32'(i));
      collect(lat, got, rd_s, rd_a);
      e = exp_q.pop_front();
      vectors++;
      if (got !== e || got.adel !== ab[i]) begin
        miscompares++;
        $display("FAIL adel[%0d] rsp: got %h expected %h (adel %b)", i, got, e, ab[i]);
      end
      vectors++;
      if (lat !== (ab[i] ? 1 : 3) || rd_s !== !ab[i]) begin
        miscompares++;
        $display("FAIL adel[%0d] path: got lat=%0d rd_en=%b expected lat=%0d rd_en=%b",
                 i, lat, rd_s, ab[i] ? 1 : 3, !ab[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_timeout();
    int lat; rsp_t got, e; logic rd_s; logic [31:0] rd_a;
    dm_enable = 1'b0;
    rsp_ready = 1'b0;
    exp_q.push_back(model(32'h20, 3'd0, 32'h900, 1'b0));
    send(32'h20, 3'd0, 32'h900);
    collect(lat, got, rd_s, rd_a);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL timeout rsp: got %h expected %h", got, e);
    end
    vectors++;
    if (lat !== int'(TIMEOUT) + 2) begin
      miscompares++;
      $display("FAIL timeout latency: got %0d expected %0d", lat, TIMEOUT + 2);
    end
    stray_at = cyc + 1;
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_data, bus_err, adel, req_ready} !== {1'b1, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL late_rvalid_resp: got valid=%b data=%h bus_err=%b adel=%b ready=%b expected 1 0 1 0 0",
               rsp_valid, rsp_data, bus_err, adel, req_ready);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    stray_at = cyc + 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++;
      if ({rsp_valid, bus_err, req_ready, mem_rd_en} !== 4'b0010) begin
        miscompares++;
        $display("FAIL stray_idle[%0d]: got valid/bus_err/ready/rd_en=%b expected 0010",
                 i, {rsp_valid, bus_err, req_ready, mem_rd_en});
      end
    end
    dm_enable = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat; rsp_t got, e; logic rd_s; logic [31:0] rd_a, a; logic [2:0] t;
    rsp_ready = 1'b0;
    exp_q.push_back({32'hFFFF_8899, 32'h500, 1'b0, 1'b0});
    send(32'h12, 3'd1, 32'h500);
    collect(lat, got, rd_s, rd_a);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e || lat !== 3) begin
      miscompares++;
      $display("FAIL stall rsp: got %h lat=%0d expected %h lat=3", got, lat, e);
    end
    req_valid = 1'b1; req_addr = 32'h14; req_type = 3'd0; req_pc = 32'hBAD;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_data, rsp_pc, req_ready, adel, bus_err} !==
          {1'b1, 32'hFFFF_8899, 32'h500, 1'b0, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got valid=%b data=%h pc=%h ready=%b expected 1 ffff8899 00000500 0",
                 i, rsp_valid, rsp_data, rsp_pc, req_ready);
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL after_handshake: got ready=%b valid=%b expected 1 0", req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    for (int n = 0; n < 12; n++) begin
      a = (n % 4 == 3) ? 32'h4000 + 32'($urandom_range(0, 15)) : 32'($urandom_range(0, 63));
      t = 3'($urandom_range(0, 7));
      exp_q.push_back(model(a, t, 32'hA00 + 32'(n), 1'b1));
      send(a, t, 32'hA00 + 32'(n));
      collect(lat, got, rd_s, rd_a);
      e = exp_q.pop_front();
      vectors++;
      if (got !== e || lat !== (e.adel ? 1 : 3)) begin
        miscompares++;
        $display("FAIL b2b[%0d] addr=%h type=%0d: got %h lat=%0d expected %h lat=%0d",
                 n, a, t, got, lat, e, e.adel ? 1 : 3);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    int lat; rsp_t got, e; logic rd_s; logic [31:0] rd_a;
    dm_enable = 1'b0;
    send(32'h10, 3'd0, 32'h700);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({req_ready, mem_rd_en, rsp_valid} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_mid_wait: got ready/rd_en/valid=%b expected 000",
               {req_ready, mem_rd_en, rsp_valid});
    end
    stray_at = cyc + 1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({rsp_valid, req_ready, mem_rd_en, adel, bus_err} !== 5'b01000) begin
        miscompares++;
        $display("FAIL reset_mid[%0d]: got valid/ready/rd_en/adel/bus_err=%b expected 01000",
                 i, {rsp_valid, req_ready, mem_rd_en, adel, bus_err});
      end
    end
    dm_enable = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(model(32'h10, 3'd0, 32'h704, 1'b1));
    send(32'h10, 3'd0, 32'h704);
    collect(lat, got, rd_s, rd_a);
    e = exp_q.pop_front();
    vectors++;
    if (got !== e || lat !== 3) begin
      miscompares++;
      $display("FAIL reset_recover: got %h lat=%0d expected %h lat=3", got, lat, e);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) dm[i] = $urandom;
    dm[4] = 32'h8899_AABB;
    test_reset();
    test_lanes();
    test_adel();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
